// File: rtl/rx_frame_ctrl.sv
// Receive-side frame sequencer: SYNC, CMD, LEN, payload, XOR checksum, with a held-frame handshake.
// Optional inter-byte timeout is built only when FRAME_TIMEOUT_EN is defined.
module rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 20000,
  localparam int        AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clock,
  input  logic          nrst,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_in_i,
  output logic          frame_valid_o,
  input  logic          frame_ack_i,
  output logic [7:0]    frame_cmd_o,
  output logic [7:0]    frame_len_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          busy_o,
  output logic          err_csum_o,
  output logic          err_len_o,
  output logic          err_ovr_o,
  output logic          err_tmo_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_LEN, ST_DATA, ST_CSUM, ST_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] csum_q, csum_d;
  logic       err_csum_q, err_csum_d;
  logic       err_len_q, err_len_d;
  logic       err_ovr_q, err_ovr_d;
  logic [7:0] rd_data_q;
  logic       buf_we;
  logic [7:0] buf_q [MAX_LEN];

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_tmo_q, err_tmo_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    err_csum_d = 1'b0;
    err_len_d  = 1'b0;
    err_ovr_d  = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: if (byte_valid_i && byte_in_i == SYNC_BYTE) begin
        csum_d  = 8'h00;
        state_d = ST_CMD;
      end
      ST_CMD: if (byte_valid_i) begin
        cmd_d   = byte_in_i;
        csum_d  = csum_q ^ byte_in_i;
        state_d = ST_LEN;
      end
      ST_LEN: if (byte_valid_i) begin
        if (byte_in_i == 8'd0 || byte_in_i > 8'(MAX_LEN)) begin
          err_len_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          len_d   = byte_in_i;
          csum_d  = csum_q ^ byte_in_i;
          idx_d   = 8'd0;
          state_d = ST_DATA;
        end
      end
      // A SYNC-valued byte here is ordinary payload; no resynchronisation.
      ST_DATA: if (byte_valid_i) begin
        buf_we = 1'b1;
        csum_d = csum_q ^ byte_in_i;
        idx_d  = idx_q + 8'd1;
        if (idx_q == len_q - 8'd1) state_d = ST_CSUM;
      end
      ST_CSUM: if (byte_valid_i) begin
        if (byte_in_i == csum_q) begin
          state_d = ST_HOLD;
        end else begin
          err_csum_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        err_ovr_d = byte_valid_i;
        if (frame_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef FRAME_TIMEOUT_EN
    // Counter runs only mid-frame and only on cycles without a byte.
    err_tmo_d = 1'b0;
    cnt_d     = '0;
    if (!byte_valid_i && state_q inside {ST_CMD, ST_LEN, ST_DATA, ST_CSUM}) begin
      if (cnt_q == TW'(TIMEOUT - 1)) begin
        err_tmo_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      idx_q      <= 8'h00;
      csum_q     <= 8'h00;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      err_csum_q <= err_csum_d;
      err_len_q  <= err_len_d;
      err_ovr_q  <= err_ovr_d;
      rd_data_q  <= buf_q[rd_addr_i];
    end
  end

  // NOTE: the payload buffer has no reset; its contents only matter after a full frame rewrites it.
  always_ff @(posedge clock) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= byte_in_i;
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!nrst) begin
      cnt_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo_o = err_tmo_q;
`else
  assign err_tmo_o = 1'b0;
`endif

  assign frame_valid_o = (state_q == ST_HOLD);
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_cmd_o   = cmd_q;
  assign frame_len_o   = len_q;
  assign rd_data_o     = rd_data_q;
  assign err_csum_o    = err_csum_q;
  assign err_len_o     = err_len_q;
  assign err_ovr_o     = err_ovr_q;

endmodule
